// File: rtl/gobou_ctrl_act.sv
// Activation-stage control pipeline: delays frame tokens by DEPTH advancing cycles,
// carries the per-frame activation mode, tracks frame state, beat count and protocol errors.
module gobou_ctrl_act #(
  parameter int DEPTH    = 2,
  parameter int OE_STAGE = 1,
  parameter int CNTW     = 16
) (
  input  logic            clk,
  input  logic            xrst,
  input  logic [1:0]      mode,
  input  logic            stall,
  input  logic            err_clr,
  input  logic            in_begin,
  input  logic            in_valid,
  input  logic            in_end,
  output logic            out_begin,
  output logic            out_valid,
  output logic            out_end,
  output logic            act_oe,
  output logic [1:0]      act_mode,
  output logic            busy,
  output logic [CNTW-1:0] beat_count,
  output logic            frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [DEPTH-1:0] beg_r;
  logic [DEPTH-1:0] vld_r;
  logic [DEPTH-1:0] end_r;
  logic [1:0]      mode_pipe_r [DEPTH];
  logic [1:0]      mode_r;
  logic            adv_s;
  logic            err_set_s;
  logic            mid_tok_s;
  logic            any_tok_s;
  logic            in_tok_s;
  logic [1:0]      stage_mode_s;

  assign adv_s        = ~stall;
  assign in_tok_s     = in_begin | in_valid | in_end;
  assign stage_mode_s = in_begin ? mode : mode_r;

  // Token/mode shift register; everything holds while stalled
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      beg_r  <= '0;
      vld_r  <= '0;
      end_r  <= '0;
      mode_r <= 2'd0;
      for (int k = 0; k < DEPTH; k++) begin
        mode_pipe_r[k] <= 2'd0;
      end
    end else if (adv_s) begin
      beg_r[0]       <= in_begin;
      vld_r[0]       <= in_valid;
      end_r[0]       <= in_end;
      mode_pipe_r[0] <= stage_mode_s;
      for (int k = 1; k < DEPTH; k++) begin
        beg_r[k]       <= beg_r[k-1];
        vld_r[k]       <= vld_r[k-1];
        end_r[k]       <= end_r[k-1];
        mode_pipe_r[k] <= mode_pipe_r[k-1];
      end
      if (in_begin) begin
        mode_r <= mode;
      end
    end
  end

  // Token occupancy; the last stage is excluded from mid_tok_s because it empties on this advance
  always_comb begin
    mid_tok_s = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      mid_tok_s = mid_tok_s | beg_r[k] | vld_r[k] | end_r[k];
    end
    any_tok_s = |(beg_r | vld_r | end_r);
  end

  // Frame FSM next state and protocol-error detection
  always_comb begin
    state_nxt_s = state_r;
    err_set_s   = 1'b0;
    if (adv_s) begin
      case (state_r)
        IDLE: begin
          if (in_begin) begin
            state_nxt_s = in_end ? DRAIN : RUN;
          end else if (in_end) begin
            err_set_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          if (in_begin) begin
            err_set_s   = 1'b1;
            state_nxt_s = in_end ? DRAIN : RUN;
          end else if (in_end) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = RUN;
          end
        end
        DRAIN: begin
          if (in_begin) begin
            state_nxt_s = in_end ? DRAIN : RUN;
          end else if (in_end) begin
            err_set_s = 1'b1;
          end else if (!mid_tok_s && !in_tok_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DRAIN;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Beat counter: reloads on begin, counts only inside a running frame, saturates
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      beat_count <= '0;
    end else if (adv_s) begin
      if (in_begin) begin
        beat_count <= CNTW'(in_valid);
      end else if ((state_r == RUN) && in_valid && (beat_count != {CNTW{1'b1}})) begin
        beat_count <= beat_count + CNTW'(1'b1);
      end
    end
  end

  // Sticky error flag; a new error wins over a same-cycle clear
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      frame_err <= 1'b0;
    end else if (err_set_s) begin
      frame_err <= 1'b1;
    end else if (err_clr) begin
      frame_err <= 1'b0;
    end
  end

  assign out_begin = beg_r[DEPTH-1];
  assign out_valid = vld_r[DEPTH-1];
  assign out_end   = end_r[DEPTH-1];
  assign act_oe    = vld_r[OE_STAGE-1] & ~stall;
  assign act_mode  = mode_pipe_r[OE_STAGE-1];
  assign busy      = (state_r != IDLE) | any_tok_s;

endmodule

// File: tb/tb_gobou_ctrl_act.sv
// Bench for gobou_ctrl_act: three parameterisations share one stimulus stream and are
// compared against a history-log reference model, plus a table and directed corner sequences.
module tb_gobou_ctrl_act;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       xrst, stall, err_clr, in_begin, in_valid, in_end;
  logic [1:0] mode;
  logic [2:0] ob, ov, oen, aoe, bsy, ferr;
  logic [5:0] am_v;
  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;
  logic [15:0] cnt_a [3];

  assign cnt_a[0] = cnt0;
  assign cnt_a[1] = cnt1;
  assign cnt_a[2] = {13'd0, cnt2};

  gobou_ctrl_act #(.DEPTH(2), .OE_STAGE(1), .CNTW(16)) dut0 (
    .clk(clk), .xrst(xrst), .mode(mode), .stall(stall), .err_clr(err_clr),
    .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
    .out_begin(ob[0]), .out_valid(ov[0]), .out_end(oen[0]), .act_oe(aoe[0]),
    .act_mode(am_v[1:0]), .busy(bsy[0]), .beat_count(cnt0), .frame_err(ferr[0]));

  gobou_ctrl_act #(.DEPTH(4), .OE_STAGE(3), .CNTW(16)) dut1 (
    .clk(clk), .xrst(xrst), .mode(mode), .stall(stall), .err_clr(err_clr),
    .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
    .out_begin(ob[1]), .out_valid(ov[1]), .out_end(oen[1]), .act_oe(aoe[1]),
    .act_mode(am_v[3:2]), .busy(bsy[1]), .beat_count(cnt1), .frame_err(ferr[1]));

  gobou_ctrl_act #(.DEPTH(2), .OE_STAGE(1), .CNTW(3)) dut2 (
    .clk(clk), .xrst(xrst), .mode(mode), .stall(stall), .err_clr(err_clr),
    .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
    .out_begin(ob[2]), .out_valid(ov[2]), .out_end(oen[2]), .act_oe(aoe[2]),
    .act_mode(am_v[5:4]), .busy(bsy[2]), .beat_count(cnt2), .frame_err(ferr[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a log of every accepted input; stage k holds the k-th most recent entry
  typedef struct packed {
    logic       b;
    logic       v;
    logic       e;
    logic [1:0] m;
  } rec_t;

  rec_t       log_q[$];
  int         depth_p [3] = '{2, 4, 2};
  int         oe_p    [3] = '{1, 3, 1};
  int         cmax    [3] = '{65535, 65535, 7};
  bit         open_m, err_m;
  logic [1:0] mode_m;
  int         cnt_m   [3];

  function automatic rec_t stage_m(int k);
    rec_t r;
    r = '0;
    if (log_q.size() >= k) r = log_q[log_q.size() - k];
    return r;
  endfunction

  task automatic model_reset();
    log_q.delete();
    open_m = 1'b0;
    err_m  = 1'b0;
    mode_m = 2'd0;
    for (int i = 0; i < 3; i++) cnt_m[i] = 0;
  endtask

  task automatic model_tick();
    rec_t r;
    bit   set;
    if (!stall) begin
      set = (in_end && !in_begin && !open_m) || (in_begin && open_m);
      r.b = in_begin;
      r.v = in_valid;
      r.e = in_end;
      r.m = in_begin ? mode : mode_m;
      log_q.push_back(r);
      if (log_q.size() > 8) void'(log_q.pop_front());
      if (in_begin) mode_m = mode;
      for (int i = 0; i < 3; i++) begin
        if (in_begin) cnt_m[i] = int'(in_valid);
        else if (open_m && in_valid && cnt_m[i] < cmax[i]) cnt_m[i] = cnt_m[i] + 1;
      end
      if (in_begin) open_m = !in_end;
      else if (in_end) open_m = 1'b0;
      if (set) err_m = 1'b1;
      else if (err_clr) err_m = 1'b0;
    end else if (err_clr) begin
      err_m = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, idx, $time, act, exp);
    end
  endtask

  task automatic check_model();
    rec_t so, sa, r;
    bit   tok;
    for (int i = 0; i < 3; i++) begin
      so  = stage_m(depth_p[i]);
      sa  = stage_m(oe_p[i]);
      tok = 1'b0;
      for (int k = 1; k <= depth_p[i]; k++) begin
        r   = stage_m(k);
        tok = tok | r.b | r.v | r.e;
      end
      chk("out_begin",  i, ob[i],  so.b);
      chk("out_valid",  i, ov[i],  so.v);
      chk("out_end",    i, oen[i], so.e);
      chk("act_oe",     i, aoe[i], sa.v && !stall);
      chk("act_mode",   i, am_v[2*i +: 2], sa.m);
      chk("busy",       i, bsy[i], open_m || tok);
      chk("beat_count", i, cnt_a[i], cnt_m[i]);
      chk("frame_err",  i, ferr[i], err_m);
    end
  endtask

  task automatic drive(input logic b, input logic v, input logic e, input logic [1:0] m,
                       input logic st, input logic clr);
    @(negedge clk);
    in_begin = b;
    in_valid = v;
    in_end   = e;
    mode     = m;
    stall    = st;
    err_clr  = clr;
    #1 check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
  endtask

  task automatic step(input logic b, input logic v, input logic e, input logic [1:0] m,
                      input logic st, input logic clr);
    drive(b, v, e, m, st, clr);
    tick();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  // Reset raised between clock edges; outputs must clear without waiting for a clock
  task automatic reset_async();
    #2 xrst = 1'b1;
    in_begin = 1'b0; in_valid = 1'b0; in_end = 1'b0;
    stall = 1'b0; err_clr = 1'b0; mode = 2'd0;
    #1 model_reset();
    check_model();
    @(posedge clk);
    @(negedge clk);
    xrst = 1'b0;
    tick();
  endtask

  typedef struct {
    logic       b, v, e;
    logic [1:0] m;
    logic       xob, xov, xoe, xaoe;
    logic [1:0] xam;
    logic       xbusy;
    int         xcnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 2};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 3};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 5};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 5};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 5};

    xrst = 1'b1;
    in_begin = 1'b0; in_valid = 1'b0; in_end = 1'b0;
    stall = 1'b0; err_clr = 1'b0; mode = 2'd0;
    model_reset();
    #1 check_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    xrst = 1'b0;
    tick();

    // Basic five-beat frame on the default configuration
    for (int t = 0; t < 8; t++) begin
      drive(tbl[t].b, tbl[t].v, tbl[t].e, tbl[t].m, 1'b0, 1'b0);
      chk("tbl_out_begin", t, ob[0],   tbl[t].xob);
      chk("tbl_out_valid", t, ov[0],   tbl[t].xov);
      chk("tbl_out_end",   t, oen[0],  tbl[t].xoe);
      chk("tbl_act_oe",    t, aoe[0],  tbl[t].xaoe);
      chk("tbl_act_mode",  t, am_v[1:0], tbl[t].xam);
      chk("tbl_busy",      t, bsy[0],  tbl[t].xbusy);
      chk("tbl_count",     t, cnt0,    tbl[t].xcnt);
      tick();
    end

    // Single-beat frame seen through the DEPTH=4 / OE_STAGE=3 instance
    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("d4_act_oe",    k, aoe[1], k == 3);
      chk("d4_out_begin", k, ob[1],  k == 4);
      chk("d4_out_end",   k, oen[1], k == 4);
      if (k == 3) chk("d4_act_mode", k, am_v[3:2], 2'd2);
      chk("d4_frame_err", k, ferr[1], 1'b0);
      tick();
    end
    idle(2);

    // Three stall cycles mid-frame with tokens offered that must be ignored
    step(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
      chk("stall_act_oe", k, aoe[0], 1'b0);
      tick();
    end
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    idle(6);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("stall_count", 0, cnt0, 4);
    tick();

    // Back-to-back frames: mode 3 then mode 0
    step(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("b2b_busy", 0, bsy[0], 1'b1);
    chk("b2b_mode_a", 0, am_v[1:0], 2'd3);
    tick();
    drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("b2b_mode_b", 0, am_v[1:0], 2'd0);
    chk("b2b_busy", 1, bsy[0], 1'b1);
    tick();
    idle(7);

    // Protocol errors: stray end, clear, begin during a running frame
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("err_stray_end", 0, ferr[0], 1'b1);
    tick();
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("err_cleared", 0, ferr[0], 1'b0);
    tick();
    step(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("err_begin_run", 0, ferr[0], 1'b1);
    chk("err_reload",    0, cnt0,    1);
    tick();
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
    idle(6);

    // Saturation of the narrow counter, then asynchronous reset mid-frame
    step(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("sat_cnt3",  0, cnt2, 7);
    chk("sat_cnt16", 0, cnt0, 10);
    tick();
    reset_async();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("post_reset_busy", 0, bsy[0], 1'b0);
    tick();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) == 0) begin
        reset_async();
      end else begin
        step($urandom_range(7) == 0, $urandom_range(1) == 0, $urandom_range(7) == 0,
             2'($urandom_range(3)), $urandom_range(4) == 0, $urandom_range(9) == 0);
      end
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
